// File: rtl/multi_timer.sv
// Multi-channel prescaled timer: per-channel up/down/ping-pong/one-shot counters
// with sticky wrap/match status, maskable interrupt and a per-channel register port.
module multi_timer #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_pulse,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_ch,
  input  logic [2:0]                wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [CW-1:0]             rd_ch,
  input  logic [2:0]                rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       wrap_evt,
  output logic [CHANNELS-1:0]       match_evt,
  output logic                      irq
);

  typedef enum logic [1:0] {M_UPWRAP, M_DNWRAP, M_PINGPONG, M_ONESHOT} mode_t;
  typedef enum logic {DIR_UP, DIR_DN} dir_t;
  typedef enum logic [2:0] {
    R_CTRL, R_MIN, R_MAX, R_CMP, R_PRE, R_VALUE, R_STATUS, R_RSVD
  } reg_t;

  logic [CHANNELS-1:0][WIDTH-1:0] rdv;
  logic [CHANNELS-1:0]            irqv;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam int unsigned IDX = g;

    logic                  en_q, en_d, iew_q, iew_d, iem_q, iem_d;
    mode_t                 mode_q, mode_d;
    dir_t                  dir_q, dir_d;
    logic [WIDTH-1:0]      min_q, min_d, max_q, max_d, cmp_q, cmp_d, val_q, val_d;
    logic [WIDTH-1:0]      nv, rdc;
    logic [PRESCALE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
    logic                  stw_q, stw_d, stm_q, stm_d, wev_q, wev_d, mev_q, mev_d;
    logic                  sel, adv;

    assign sel = wr_en && (32'(wr_ch) == IDX);

    always_comb begin
      en_d   = en_q;   mode_d = mode_q; dir_d  = dir_q;
      iew_d  = iew_q;  iem_d  = iem_q;
      min_d  = min_q;  max_d  = max_q;  cmp_d  = cmp_q;
      pre_d  = pre_q;  pcnt_d = pcnt_q; val_d  = val_q;
      nv     = val_q;  adv    = 1'b0;
      wev_d  = 1'b0;   mev_d  = 1'b0;

      // A VALUE write or an en=0 CTRL write on this edge suppresses the advance.
      if (clk_pulse && en_q &&
          !(sel && ((reg_t'(wr_addr) == R_CTRL && !wr_data[0]) ||
                    reg_t'(wr_addr) == R_VALUE))) begin
        if (pcnt_q == pre_q) begin
          pcnt_d = '0;
          adv    = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PRESCALE_W'(1);
        end
      end

      if (adv) begin
        unique case (mode_q)
          M_UPWRAP: begin
            if (val_q < max_q) nv = val_q + WIDTH'(1);
            else begin nv = min_q; wev_d = 1'b1; end
          end
          M_DNWRAP: begin
            if (val_q > min_q) nv = val_q - WIDTH'(1);
            else begin nv = max_q; wev_d = 1'b1; end
          end
          M_PINGPONG: begin
            if (dir_q == DIR_UP) begin
              if (val_q < max_q) nv = val_q + WIDTH'(1);
              else begin
                dir_d = DIR_DN;
                wev_d = 1'b1;
                nv    = (val_q > min_q) ? val_q - WIDTH'(1) : val_q;
              end
            end else begin
              if (val_q > min_q) nv = val_q - WIDTH'(1);
              else begin
                dir_d = DIR_UP;
                wev_d = 1'b1;
                nv    = (val_q < max_q) ? val_q + WIDTH'(1) : val_q;
              end
            end
          end
          M_ONESHOT: begin
            if (val_q > min_q) begin
              nv = val_q - WIDTH'(1);
              if (nv == min_q) begin en_d = 1'b0; wev_d = 1'b1; end
            end else begin
              nv    = min_q;
              en_d  = 1'b0;
              wev_d = 1'b1;
            end
          end
        endcase
        val_d = nv;
        mev_d = (nv == cmp_q);
      end

      if (sel) begin
        case (reg_t'(wr_addr))
          R_CTRL: begin
            en_d   = wr_data[0];
            mode_d = mode_t'(wr_data[2:1]);
            iew_d  = wr_data[3];
            iem_d  = wr_data[4];
            if (mode_t'(wr_data[2:1]) != mode_q) dir_d = DIR_UP;
            if (!en_q && wr_data[0]) pcnt_d = '0;
          end
          R_MIN:   min_d = wr_data;
          R_MAX:   max_d = wr_data;
          R_CMP:   cmp_d = wr_data;
          R_PRE:   begin pre_d = wr_data[PRESCALE_W-1:0]; pcnt_d = '0; end
          R_VALUE: begin val_d = wr_data; pcnt_d = '0; end
          default: ;
        endcase
      end

      stw_d = (stw_q && !(sel && reg_t'(wr_addr) == R_STATUS && wr_data[0])) || wev_d;
      stm_d = (stm_q && !(sel && reg_t'(wr_addr) == R_STATUS && wr_data[1])) || mev_d;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q  <= 1'b0;   mode_q <= M_UPWRAP; dir_q <= DIR_UP;
        iew_q <= 1'b0;   iem_q  <= 1'b0;
        min_q <= '0;     max_q  <= '1;       cmp_q <= '1;
        pre_q <= '0;     pcnt_q <= '0;       val_q <= '0;
        stw_q <= 1'b0;   stm_q  <= 1'b0;
        wev_q <= 1'b0;   mev_q  <= 1'b0;
      end else begin
        en_q  <= en_d;   mode_q <= mode_d;   dir_q <= dir_d;
        iew_q <= iew_d;  iem_q  <= iem_d;
        min_q <= min_d;  max_q  <= max_d;    cmp_q <= cmp_d;
        pre_q <= pre_d;  pcnt_q <= pcnt_d;   val_q <= val_d;
        stw_q <= stw_d;  stm_q  <= stm_d;
        wev_q <= wev_d;  mev_q  <= mev_d;
      end
    end

    always_comb begin
      rdc = '0;
      case (reg_t'(rd_addr))
        R_CTRL:   rdc = WIDTH'({iem_q, iew_q, mode_q, en_q});
        R_MIN:    rdc = min_q;
        R_MAX:    rdc = max_q;
        R_CMP:    rdc = cmp_q;
        R_PRE:    rdc = WIDTH'(pre_q);
        R_VALUE:  rdc = val_q;
        R_STATUS: rdc = WIDTH'({stm_q, stw_q});
        default:  rdc = '0;
      endcase
    end

    assign rdv[g]                    = rdc;
    assign irqv[g]                   = (stw_q && iew_q) || (stm_q && iem_q);
    assign value[g*WIDTH +: WIDTH]   = val_q;
    assign wrap_evt[g]               = wev_q;
    assign match_evt[g]              = mev_q;
  end

  assign irq = |irqv;

  always_comb begin
    rd_data = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      if (32'(rd_ch) == n) rd_data = rdv[n];
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized register
// traffic and ticks compared against a behavioural per-channel model.
module tb_multi_timer;
  localparam int CH = 4, W = 16, PW = 8, CW = 2;
  localparam int unsigned ONES = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic rst, clk_pulse, wr_en, irq;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [2:0] wr_addr, rd_addr;
  logic [W-1:0] wr_data, rd_data;
  logic [CH*W-1:0] value;
  logic [CH-1:0] wrap_evt, match_evt;

  multi_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .clk_pulse(clk_pulse), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .value(value), .wrap_evt(wrap_evt), .match_evt(match_evt),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model, one entry per channel.
  int unsigned m_en[CH], m_mode[CH], m_iew[CH], m_iem[CH], m_min[CH], m_max[CH];
  int unsigned m_cmp[CH], m_pre[CH], m_pc[CH], m_val[CH], m_dir[CH], m_sw[CH], m_sm[CH];
  bit m_we[CH], m_me[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_iew[c] = 0; m_iem[c] = 0; m_min[c] = 0;
      m_max[c] = ONES; m_cmp[c] = ONES; m_pre[c] = 0; m_pc[c] = 0; m_val[c] = 0;
      m_dir[c] = 0; m_sw[c] = 0; m_sm[c] = 0; m_we[c] = 0; m_me[c] = 0;
    end
  endtask

  task automatic model_edge(input bit p, input bit w, input int wc, input int a,
                            input int unsigned d);
    bit ws, adv, ew;
    int unsigned v, nv, lo, hi, en0, nm;
    for (int c = 0; c < CH; c++) begin
      ws = w && (wc == c);
      adv = 0; ew = 0; en0 = m_en[c];
      m_we[c] = 0; m_me[c] = 0;
      if (p && m_en[c] != 0 && !(ws && ((a == 0 && d[0] == 1'b0) || a == 5))) begin
        if (m_pc[c] == m_pre[c]) begin m_pc[c] = 0; adv = 1; end
        else m_pc[c]++;
      end
      if (adv) begin
        v = m_val[c]; lo = m_min[c]; hi = m_max[c]; nv = v;
        case (m_mode[c])
          0: if (v < hi) nv = v + 1; else begin nv = lo; ew = 1; end
          1: if (v > lo) nv = v - 1; else begin nv = hi; ew = 1; end
          2: if (m_dir[c] == 0) begin
               if (v < hi) nv = v + 1;
               else begin m_dir[c] = 1; ew = 1; nv = (v > lo) ? v - 1 : v; end
             end else begin
               if (v > lo) nv = v - 1;
               else begin m_dir[c] = 0; ew = 1; nv = (v < hi) ? v + 1 : v; end
             end
          default: if (v > lo) begin
               nv = v - 1;
               if (nv == lo) begin m_en[c] = 0; ew = 1; end
             end else begin nv = lo; m_en[c] = 0; ew = 1; end
        endcase
        m_val[c] = nv; m_we[c] = ew; m_me[c] = (nv == m_cmp[c]);
      end
      if (ws) begin
        case (a)
          0: begin
            nm = (d >> 1) & 3;
            if (nm != m_mode[c]) m_dir[c] = 0;
            m_en[c] = d & 1; m_mode[c] = nm;
            m_iew[c] = (d >> 3) & 1; m_iem[c] = (d >> 4) & 1;
            if (en0 == 0 && d[0]) m_pc[c] = 0;
          end
          1: m_min[c] = d;
          2: m_max[c] = d;
          3: m_cmp[c] = d;
          4: begin m_pre[c] = d & 8'hFF; m_pc[c] = 0; end
          5: begin m_val[c] = d; m_pc[c] = 0; end
          6: begin
            if (d[0]) m_sw[c] = 0;
            if (d[1]) m_sm[c] = 0;
          end
          default: ;
        endcase
      end
      if (m_we[c]) m_sw[c] = 1;
      if (m_me[c]) m_sm[c] = 1;
    end
  endtask

  function automatic int unsigned model_read(input int c, input int a);
    case (a)
      0: return (m_iem[c] << 4) | (m_iew[c] << 3) | (m_mode[c] << 1) | m_en[c];
      1: return m_min[c];
      2: return m_max[c];
      3: return m_cmp[c];
      4: return m_pre[c];
      5: return m_val[c];
      6: return (m_sm[c] << 1) | m_sw[c];
      default: return 0;
    endcase
  endfunction

  function automatic bit model_irq();
    bit r = 0;
    for (int c = 0; c < CH; c++)
      r |= (m_sw[c] != 0 && m_iew[c] != 0) || (m_sm[c] != 0 && m_iem[c] != 0);
    return r;
  endfunction

  task automatic step(input bit p, input bit w, input int c, input int a,
                      input int unsigned d);
    logic [CH-1:0] ew, em;
    int rc, ra;
    @(negedge clk);
    clk_pulse = p; wr_en = w; wr_ch = CW'(c); wr_addr = 3'(a); wr_data = W'(d);
    rc = $urandom_range(0, CH - 1); ra = $urandom_range(0, 7);
    rd_ch = CW'(rc); rd_addr = 3'(ra);
    @(posedge clk);
    model_edge(p, w, c, a, d);
    #1;
    clk_pulse = 1'b0; wr_en = 1'b0;
    for (int n = 0; n < CH; n++) begin
      check($sformatf("value[%0d]", n), value[n*W +: W], m_val[n]);
      ew[n] = m_we[n]; em[n] = m_me[n];
    end
    check("wrap_evt", wrap_evt, ew);
    check("match_evt", match_evt, em);
    check("irq", irq, model_irq());
    check($sformatf("rd_data ch%0d a%0d", rc, ra), rd_data, model_read(rc, ra));
  endtask

  task automatic wr(input int c, input int a, input int unsigned d);
    step(1'b0, 1'b1, c, a, d);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic peek(input string tag, input int c, input int a, input int unsigned exp);
    rd_ch = CW'(c); rd_addr = 3'(a);
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic rand_steps(input int n);
    int c, a;
    int unsigned d;
    bit p, w;
    for (int i = 0; i < n; i++) begin
      c = $urandom_range(0, CH - 1);
      a = $urandom_range(0, 7);
      d = ($urandom_range(0, 3) == 0) ? ($urandom & ONES) : $urandom_range(0, 15);
      if (a == 4) d = $urandom_range(0, 3);
      if (a == 0) d = $urandom_range(0, 31) | ($urandom_range(0, 2) != 0 ? 1 : 0);
      w = ($urandom_range(0, 5) == 0);
      p = $urandom_range(0, 1);
      if (w && (a == 4 || (a == 0 && d[0]))) p = 1'b0;
      step(p, w, c, a, d);
    end
  endtask

  int unsigned seq0[4] = '{5, 2, 3, 4};
  int unsigned seq2[6] = '{1, 2, 1, 0, 1, 2};
  int unsigned seq3[5] = '{2, 1, 0, 0, 0};

  initial begin
    rst = 1'b1; clk_pulse = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0;
    wr_data = '0; rd_ch = '0; rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset value", value, '0);
    check("reset wrap_evt", wrap_evt, '0);
    check("reset irq", irq, 1'b0);
    peek("reset MAX", 1, 2, ONES);
    peek("reset CMP", 2, 3, ONES);
    @(negedge clk);
    rst = 1'b0;

    // Up-wrap on channel 0.
    wr(0, 1, 2); wr(0, 2, 5); wr(0, 5, 4); wr(0, 4, 0); wr(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("upwrap v%0d", i), value[0 +: W], seq0[i]);
      check($sformatf("upwrap evt%0d", i), wrap_evt[0], i == 1);
    end
    peek("upwrap status", 0, 6, 1);
    check("upwrap irq", irq, 1'b0);

    // Prescaled down-wrap on channel 1.
    wr(1, 2, 3); wr(1, 5, 3); wr(1, 4, 2); wr(1, 0, 3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("prescale v%0d", k), value[W +: W], (k < 12) ? 3 - k / 3 : 3);
      check($sformatf("prescale evt%0d", k), wrap_evt[1], k == 12);
    end

    // Ping-pong on channel 2.
    wr(2, 2, 2); wr(2, 3, 1); wr(2, 5, 0); wr(2, 0, 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("pingpong v%0d", i), value[2*W +: W], seq2[i]);
      check($sformatf("pingpong wrap%0d", i), wrap_evt[2], i == 2 || i == 4);
      check($sformatf("pingpong match%0d", i), match_evt[2], i % 2 == 0);
    end

    // One-shot on channel 3 with wrap interrupt.
    wr(3, 5, 3); wr(3, 0, 15);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("oneshot v%0d", i), value[3*W +: W], seq3[i]);
    end
    peek("oneshot ctrl", 3, 0, 14);
    check("oneshot irq set", irq, 1'b1);
    wr(3, 6, 1);
    check("oneshot irq clr", irq, 1'b0);
    wr(3, 5, 1); wr(3, 0, 15);
    step(1'b1, 1'b1, 3, 6, 1);
    check("clear+event irq", irq, 1'b1);
    peek("clear+event status", 3, 6, 1);

    // VALUE write colliding with an advance on channel 0.
    step(1'b1, 1'b1, 0, 5, 7);
    check("collide value", value[0 +: W], 7);
    check("collide wrap", wrap_evt[0], 1'b0);
    check("collide match", match_evt[0], 1'b0);

    rand_steps(2500);

    // Asynchronous reset mid-count.
    wr(3, 0, 9); wr(0, 5, 4); wr(0, 0, 1);
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("async rst value", value, '0);
    check("async rst irq", irq, 1'b0);
    peek("async rst MAX", 0, 2, ONES);
    @(negedge clk);
    rst = 1'b0;
    rand_steps(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_timer.md
# multi_timer

Multi-channel timer for the timer subsystem: `CHANNELS` independent `WIDTH`-bit counters, each advancing on a shared `clk_pulse` tick through its own prescaler. Each channel has four modes: up-wrap, down-wrap, up/down ping-pong and one-shot down. Each channel produces wrap and compare-match events with sticky status and a maskable interrupt. It is configured through a simple per-channel register write/read port.

## Interface
- `CHANNELS`, 4: number of channels (1-16).
- `WIDTH`, 16: counter width; minimum 8.
- `PRESCALE_W`, 8: prescaler width.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `clk_pulse` input 1: shared count tick, one `clk` wide.
- `wr_en` input 1: register write strobe.
- `wr_ch` input `$clog2(CHANNELS)` (min 1): channel for the write.
- `wr_addr` input 3: register select for the write.
- `wr_data` input `WIDTH`: write data.
- `rd_ch`, `rd_addr` input: channel and register select for the read; same widths as the write selects.
- `rd_data` output `WIDTH`: combinational read data.
- `value` output `CHANNELS*WIDTH`: all counters; channel n at bits [n*WIDTH +: WIDTH].
- `wrap_evt` output `CHANNELS`: one-cycle wrap/turn/expire pulse per channel.
- `match_evt` output `CHANNELS`: one-cycle compare-match pulse per channel.
- `irq` output 1: OR over channels of (status AND enables).

## Operation
- Register map, per channel:
  - 0 CTRL: bit0 `en`, bits2:1 `mode`, bit3 `ie_wrap`, bit4 `ie_match`.
  - 1 MIN.
  - 2 MAX.
  - 3 CMP.
  - 4 PRE (low `PRESCALE_W` bits).
  - 5 VALUE: a write loads the counter; a read returns the live value.
  - 6 STATUS: bit0 wrap, bit1 match, write-1-to-clear.
  - 7: reserved; writes are ignored and reads return 0.
  - Unused bits read 0.
- Reset values:
  - CTRL, MIN, PRE, VALUE, STATUS: 0.
  - MAX, CMP: all ones.
  - Direction: up.
  - Prescaler count: 0.
  - `wrap_evt`, `match_evt`, `irq`: 0.
- Prescaler: when `clk_pulse` is high and `en`=1:
  - If the prescaler count equals PRE, the count returns to 0 and the channel advances.
  - Otherwise the count increments.
  - PRE=0 means the channel advances on every tick.
  - The count is held while `en`=0.
  - The count is cleared on any write to PRE or VALUE, and on an `en` 0→1 write.
- Advance rules, by mode:
  - Mode 0, up-wrap: if v<MAX, v+1; else v=MIN with wrap event.
  - Mode 1, down-wrap: if v>MIN, v-1; else v=MAX with wrap event.
  - Mode 2, ping-pong:
    - Up direction: if v<MAX, v+1. Else direction becomes down, v-1 if v>MIN (otherwise v holds), with wrap event.
    - Down direction: mirror image at MIN.
  - Mode 3, one-shot down:
    - If v>MIN, v-1. If the result equals MIN, `en` clears and a wrap event fires.
    - If v≤MIN, v=MIN, `en` clears and a wrap event fires.
- Match event: fires on any advance whose new value equals CMP. No event fires on a VALUE load.
- Arithmetic is unsigned modulo 2^`WIDTH`. MIN>MAX is legal; the rules above apply literally.
- Events set STATUS bits. `irq` = OR over channels of (wrap & `ie_wrap`) | (match & `ie_match`).
- A CTRL write changing `mode` resets direction to up.
- Simultaneous events, same channel, same cycle:
  - A VALUE write overrides the advance; the prescaler is cleared.
  - A CTRL write of `en`=0 blocks the advance.
  - A STATUS clear and a new event on the same bit leave the bit set.
  - A MIN/MAX/CMP write takes effect from the next advance.
  - A one-shot expiry on the same edge as a CTRL write: the written `en` value wins.
- Writes with `wr_ch` ≥ CHANNELS are ignored; reads of such a channel return 0.

## Timing
- All state is registered on `posedge clk`.
- `value` updates on the edge that samples the qualifying `clk_pulse`.
- `wrap_evt` and `match_evt` are registered. Each is high for exactly one cycle, the same cycle in which the new value is first visible.
- STATUS and `irq` reflect an event from that same cycle. `irq` therefore rises together with the event pulse.
- Register writes are visible on `rd_data` the cycle after `wr_en`.
- `rd_data` is combinational from `rd_ch`/`rd_addr` and the current state.
- Asserting `rst` at any time forces the reset values immediately, including mid-prescale and mid-one-shot. Operation restarts on the first tick after release.

## Test plan
- Up-wrap, channel 0: MIN=2, MAX=5, VALUE=4, PRE=0, en=1, 4 ticks → 5, 2, 3, 4. `wrap_evt[0]` pulses once, with value 2. STATUS=1. `irq` stays low while `ie_wrap`=0.
- Prescale, channel 1, mode 1: PRE=2, VALUE=3, MIN=0, MAX=3, 9 ticks → value changes only on ticks 3, 6, 9 (2, 1, 0). Ticks 1-8 produce no `wrap_evt[1]`; on tick 9 value is 0 and no wrap occurs. A 10th-phase cycle of 3 more ticks → value 3 with `wrap_evt[1]`.
- Ping-pong, channel 2: MIN=0, MAX=2, VALUE=0, 6 ticks → 1, 2, 1, 0, 1, 2. Wraps occur at the turns; CMP=1 gives `match_evt` on ticks 1, 3, 5.
- One-shot, channel 3: VALUE=3, MIN=0, `ie_wrap`=1, 5 ticks → 2, 1, 0; `en` reads 0; value holds at 0. `irq`=1 until STATUS is written with 1. Clear and new event in the same cycle → the bit stays set.
- Collision and reset: a VALUE write of 7 on the tick edge → value 7 with no event. Asserting `rst` mid-count → value 0, MAX all ones, `irq` 0 immediately.
